// File: rtl/fp_div_pkg.sv
// ============================================================================
//  Module      : fp_div_pkg
//  Description : Shared constants, special-case codes, flag indices and the
//                S1 pipeline record for the divider normalize/pack stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_div_pkg;

    localparam int BIAS   = 127;          // exponent bias added to (rexp - dexp)
    localparam int EXP_W  = 8;            // IEEE-754 single exponent field
    localparam int EXP_IW = 10;           // internal signed exponent width
    localparam int MANT_W = 23;           // stored fraction width
    localparam int QM_W   = 26;           // 1 integer + 23 fraction + guard + round
    localparam int RND_W  = MANT_W + 2;   // {hidden, frac, guard} denormalize width

    typedef enum logic [2:0] {
        SPC_NORM = 3'b000,
        SPC_ZERO = 3'b001,
        SPC_INF  = 3'b010,
        SPC_NAN  = 3'b011,
        SPC_DZ   = 3'b100
    } special_e;

    localparam int FLG_OVF = 3;
    localparam int FLG_UNF = 2;
    localparam int FLG_INX = 1;
    localparam int FLG_DZ  = 0;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Normalized quotient handed from S1 to S2; exp is two's complement.
    typedef struct packed {
        logic              sign;
        special_e          special;
        logic [EXP_IW-1:0] exp;
        logic [MANT_W-1:0] frac;
        logic              g;
        logic              s;
    } s1_t;

endpackage

`default_nettype wire

// File: rtl/fp_div_normalize_pack_if.sv
// ============================================================================
//  Module      : fp_div_normalize_pack_if
//  Description : Upstream quotient and downstream result valid/ready bundle
//                for the divider normalize/pack stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_div_normalize_pack_if;
    import fp_div_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_rexp;
    logic [EXP_W-1:0]        in_dexp;
    logic [QM_W-1:0]         in_qmant;
    logic                    in_sticky;
    logic [2:0]              in_special;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_q;
    logic [3:0]              out_flags;

    // Producer of quotients and consumer of results.
    modport master (
        output in_valid, in_sign, in_rexp, in_dexp, in_qmant, in_sticky, in_special,
        output out_ready,
        input  in_ready, out_valid, out_q, out_flags
    );

    // The normalize/pack stage itself.
    modport slave (
        input  in_valid, in_sign, in_rexp, in_dexp, in_qmant, in_sticky, in_special,
        input  out_ready,
        output in_ready, out_valid, out_q, out_flags
    );

endinterface

`default_nettype wire

// File: rtl/fp_div_round_rne.sv
// ============================================================================
//  Module      : fp_div_round_rne
//  Description : Round-to-nearest-even of a fraction with guard and sticky.
//                Reports carry out of the fraction and inexactness.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_round_rne
    import fp_div_pkg::*;
(
    input  logic [MANT_W-1:0] frac,
    input  logic              g,
    input  logic              s,
    output logic [MANT_W-1:0] frac_rnd,
    output logic              carry,
    output logic              inexact
);

    logic w_round_up;

    // Round up above half, or at exactly half when the kept LSB is odd.
    always_comb begin
        w_round_up          = g & (s | frac[0]);
        {carry, frac_rnd}   = {1'b0, frac} + {{MANT_W{1'b0}}, w_round_up};
        inexact             = g | s;
    end

endmodule

`default_nettype wire

// File: rtl/fp_div_normalize_pack.sv
// ============================================================================
//  Module      : fp_div_normalize_pack
//  Description : Post-divide stage after the radix-4 SRT core. S1 forms the
//                biased exponent and normalizes the quotient to 1.f; S2 rounds
//                to nearest-even, detects overflow/underflow and packs an
//                IEEE-754 single with {ovf, unf, inx, dz} flags.
//                Optional macro DIV_SUBNORMAL_EN: produce gradual-underflow
//                subnormals instead of flushing tiny results to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_normalize_pack
    import fp_div_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    fp_div_normalize_pack_if.slave   bus
);

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              r_s1_valid;
    s1_t               r_s1;
    s1_t               w_s1_next;
    logic [EXP_IW-1:0] w_exp0;

    logic [MANT_W-1:0] w_rnd_frac;
    logic              w_rnd_g;
    logic              w_rnd_s;
    logic [MANT_W-1:0] w_frac_rnd;
    logic              w_carry;
    logic              w_inexact;
    logic [EXP_IW-1:0] w_exp_rnd;

    logic [31:0]       w_q;
    logic [3:0]        w_flags;
    logic              r_out_valid;
    logic [31:0]       r_out_q;
    logic [3:0]        r_out_flags;

    // Pipeline advance: S2 frees when empty or drained, S1 when S2 can take it.
    always_comb begin
        w_s2_adv = ~r_out_valid | bus.out_ready;
        w_s1_adv = ~r_s1_valid | w_s2_adv;
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_q     = r_out_q;
    assign bus.out_flags = r_out_flags;

    // S1: biased exponent difference and one-bit normalization of the quotient.
    always_comb begin
        w_exp0              = {2'b00, bus.in_rexp} - {2'b00, bus.in_dexp} + EXP_IW'(BIAS);
        w_s1_next.sign      = bus.in_sign;
        w_s1_next.special   = special_e'(bus.in_special);
        if (bus.in_qmant[QM_W-1]) begin
            w_s1_next.exp   = w_exp0;
            w_s1_next.frac  = bus.in_qmant[QM_W-2:2];
            w_s1_next.g     = bus.in_qmant[1];
            w_s1_next.s     = bus.in_qmant[0] | bus.in_sticky;
        end else begin
            // Quotient below 1.0: shift left one place and compensate.
            w_s1_next.exp   = w_exp0 - EXP_IW'(1);
            w_s1_next.frac  = bus.in_qmant[QM_W-3:1];
            w_s1_next.g     = bus.in_qmant[0];
            w_s1_next.s     = bus.in_sticky;
        end
    end

    // S1 register: capture a quotient whenever the stage is free to move.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_s1_next;
            end
        end
    end

`ifdef DIV_SUBNORMAL_EN
    logic              w_tiny;
    logic [EXP_IW-1:0] w_sh_raw;
    logic [4:0]        w_sh_amt;
    logic [RND_W-1:0]  w_mant;
    logic [RND_W-1:0]  w_mask;
    logic [RND_W-2:0]  w_mant_sh;
    logic              w_lost;

    // Tiny results: denormalize {1,frac,g} to the 2^-126 scale before rounding.
    always_comb begin
        w_tiny    = ($signed(r_s1.exp) < $signed(EXP_IW'(1)));
        w_sh_raw  = EXP_IW'(1) - r_s1.exp;
        w_sh_amt  = (w_sh_raw > EXP_IW'(RND_W)) ? 5'(RND_W) : w_sh_raw[4:0];
        w_mant    = {1'b1, r_s1.frac, r_s1.g};
        w_mant_sh = (RND_W-1)'(w_mant >> w_sh_amt);
        w_mask    = ~({RND_W{1'b1}} << w_sh_amt);
        w_lost    = |(w_mant & w_mask);
        if (w_tiny) begin
            w_rnd_frac = w_mant_sh[RND_W-2:1];
            w_rnd_g    = w_mant_sh[0];
            w_rnd_s    = r_s1.s | w_lost;
        end else begin
            w_rnd_frac = r_s1.frac;
            w_rnd_g    = r_s1.g;
            w_rnd_s    = r_s1.s;
        end
    end
`else
    // Rounding always operates on the normalized fraction.
    always_comb begin
        w_rnd_frac = r_s1.frac;
        w_rnd_g    = r_s1.g;
        w_rnd_s    = r_s1.s;
    end
`endif

    fp_div_round_rne u_round (
        .frac     (w_rnd_frac),
        .g        (w_rnd_g),
        .s        (w_rnd_s),
        .frac_rnd (w_frac_rnd),
        .carry    (w_carry),
        .inexact  (w_inexact)
    );

    // S2: range check on the rounded exponent and IEEE packing; specials bypass.
    always_comb begin
        w_exp_rnd = r_s1.exp + {{(EXP_IW-1){1'b0}}, w_carry};
        w_q       = '0;
        w_flags   = '0;
        case (r_s1.special)
            SPC_NORM: begin
`ifdef DIV_SUBNORMAL_EN
                if (w_tiny) begin
                    // A carry into the hidden bit lands exactly on exponent field 1.
                    w_q              = {r_s1.sign, 7'b0, w_carry, w_frac_rnd};
                    w_flags[FLG_UNF] = w_inexact;
                    w_flags[FLG_INX] = w_inexact;
                end else if ($signed(w_exp_rnd) >= $signed(EXP_IW'(255))) begin
                    w_q              = {r_s1.sign, EXP_MAX, {MANT_W{1'b0}}};
                    w_flags[FLG_OVF] = 1'b1;
                    w_flags[FLG_INX] = 1'b1;
                end else begin
                    w_q              = {r_s1.sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
                    w_flags[FLG_INX] = w_inexact;
                end
`else
                if ($signed(w_exp_rnd) >= $signed(EXP_IW'(255))) begin
                    w_q              = {r_s1.sign, EXP_MAX, {MANT_W{1'b0}}};
                    w_flags[FLG_OVF] = 1'b1;
                    w_flags[FLG_INX] = 1'b1;
                end else if ($signed(w_exp_rnd) < $signed(EXP_IW'(1))) begin
                    w_q              = {r_s1.sign, 31'h0};
                    w_flags[FLG_UNF] = 1'b1;
                    w_flags[FLG_INX] = 1'b1;
                end else begin
                    w_q              = {r_s1.sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
                    w_flags[FLG_INX] = w_inexact;
                end
`endif
            end
            SPC_ZERO: w_q = {r_s1.sign, 31'h0};
            SPC_INF:  w_q = {r_s1.sign, EXP_MAX, {MANT_W{1'b0}}};
            SPC_NAN:  w_q = QNAN;
            SPC_DZ: begin
                w_q             = {r_s1.sign, EXP_MAX, {MANT_W{1'b0}}};
                w_flags[FLG_DZ] = 1'b1;
            end
            default:  w_q = QNAN;
        endcase
    end

    // S2 register: result holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_flags <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_q     <= w_q;
                r_out_flags <= w_flags;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_div_normalize_pack.sv
// ============================================================================
//  Module      : tb_fp_div_normalize_pack
//  Description : Self-checking bench for fp_div_normalize_pack: directed
//                vector table, backpressure and reset sequences, and random
//                traffic scored against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_div_normalize_pack;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    fp_div_normalize_pack_if bus ();

    fp_div_normalize_pack dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  rexp;
        logic [7:0]  dexp;
        logic [25:0] qmant;
        logic        sticky;
        logic [2:0]  special;
        logic [31:0] exp_q;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t        vecs[$];
    logic [35:0] sb[$];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic sg, input logic [7:0] re, input logic [7:0] de,
                           input logic [25:0] qm, input logic st, input logic [2:0] sp,
                           input logic [31:0] q, input logic [3:0] f);
        vec_t v;
        v.name = n; v.sign = sg; v.rexp = re; v.dexp = de; v.qmant = qm;
        v.sticky = st; v.special = sp; v.exp_q = q; v.exp_flags = f;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.in_sign    = v.sign;
        bus.in_rexp    = v.rexp;
        bus.in_dexp    = v.dexp;
        bus.in_qmant   = v.qmant;
        bus.in_sticky  = v.sticky;
        bus.in_special = v.special;
    endtask

    // Reference: treat {qmant,sticky} as an integer scaled by 2^(e0-153) and
    // round it to the weight of the target LSB (2^(E-150) normal, 2^-149 tiny).
    function automatic logic [35:0] ref_model(input logic sign, input logic [7:0] rexp,
                                              input logic [7:0] dexp, input logic [25:0] qmant,
                                              input logic sticky, input logic [2:0] special);
        logic [31:0] q;
        logic [3:0]  f;
        longint      x, keep, rem, half;
        int          e0, p, be, d;
        logic        up, nz;
        q = '0;
        f = '0;
        case (special)
            3'd1: q = {sign, 31'h0};
            3'd2: q = {sign, 8'hFF, 23'h0};
            3'd3: q = 32'h7FC00000;
            3'd4: begin q = {sign, 8'hFF, 23'h0}; f = 4'b0001; end
            3'd0: begin
                e0 = int'(rexp) - int'(dexp) + 127;
                x  = longint'({qmant, sticky});
                p  = qmant[25] ? 26 : 25;
                be = e0 + p - 26;
                d  = p - 23;
`ifdef DIV_SUBNORMAL_EN
                if (be <= 0) d = 4 - e0;
`endif
                if (d > 40) begin
                    keep = 0; nz = (x != 0); up = 1'b0;
                end else begin
                    keep = x >> d;
                    rem  = x - (keep << d);
                    half = longint'(1) << (d - 1);
                    nz   = (rem != 0);
                    up   = (rem > half) || ((rem == half) && keep[0]);
                end
                keep = keep + (up ? 1 : 0);
`ifdef DIV_SUBNORMAL_EN
                if (be <= 0) begin
                    q = {sign, 31'(keep)};
                    f = {1'b0, nz, nz, 1'b0};
                end else
`endif
                begin
                    if (keep == (longint'(1) << 24)) begin
                        be++;
                        keep = longint'(1) << 23;
                    end
                    if (be >= 255) begin
                        q = {sign, 8'hFF, 23'h0}; f = 4'b1010;
                    end else if (be <= 0) begin
                        q = {sign, 31'h0}; f = 4'b0110;
                    end else begin
                        q = {sign, 8'(be), 23'(keep - (longint'(1) << 23))};
                        f = {2'b00, nz, 1'b0};
                    end
                end
            end
            default: q = 32'h7FC00000;
        endcase
        return {q, f};
    endfunction

    task automatic gen_rand(output vec_t v);
        int e0, de, mode;
        logic [31:0] r;
        v.name   = "rand";
        v.sign   = 1'($urandom);
        v.special = ($urandom_range(0, 99) < 85) ? 3'd0 : 3'($urandom_range(1, 4));
        v.rexp   = 8'($urandom_range(0, 255));
        mode     = $urandom_range(0, 3);
        case (mode)
            1:       e0 = int'($urandom_range(0, 35)) - 30;
            2:       e0 = int'($urandom_range(245, 260));
            3:       e0 = int'($urandom_range(1, 254));
            default: e0 = int'($urandom_range(0, 255)) - int'(v.rexp) + 127;
        endcase
        de = int'(v.rexp) - e0 + 127;
        v.dexp = (de >= 0 && de <= 255) ? 8'(de) : 8'($urandom_range(0, 255));
        r = $urandom;
        v.qmant  = r[25:0];
        if (!v.qmant[25]) v.qmant[24] = 1'b1;
        v.sticky = 1'($urandom);
        case ($urandom_range(0, 7))
            0: begin v.qmant[1:0] = 2'b10; v.sticky = 1'b0; end
            1: v.qmant = 26'h3FFFFFF;
            2: v.qmant = 26'h1FFFFFF;
            default: ;
        endcase
        v.exp_q = '0;
        v.exp_flags = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int waitc, lat;
        @(negedge clk);
        drive(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk); #1; waitc++;
        end
        check({v.name, "_accept"}, 36'(bus.in_ready), 36'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        check({v.name, "_latency"}, 36'(lat), 36'(2));
        check({v.name, "_q"}, 36'(bus.out_q), 36'(v.exp_q));
        check({v.name, "_flags"}, 36'(bus.out_flags), 36'(v.exp_flags));
    endtask

    initial begin
        vec_t        v, va, vb, vc;
        logic [35:0] exp_bp[3];
        logic [35:0] e;
        int          got, emitted, have;
        logic        c_acc, prev_stall;
        logic [35:0] prev_out;

        resetn         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_rexp    = '0;
        bus.in_dexp    = '0;
        bus.in_qmant   = '0;
        bus.in_sticky  = 1'b0;
        bus.in_special = '0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 36'(bus.out_valid), 36'(0));
        check("reset_out_q", 36'(bus.out_q), 36'(0));
        check("reset_out_flags", 36'(bus.out_flags), 36'(0));
        check("reset_in_ready", 36'(bus.in_ready), 36'(1));
        @(negedge clk);
        resetn = 1'b1;

        add_vec("div_3_2",   1'b0, 8'd128, 8'd128, 26'h3000000, 1'b0, 3'd0, 32'h3FC00000, 4'b0000);
        add_vec("div_2_3",   1'b0, 8'd128, 8'd128, 26'h1555555, 1'b1, 3'd0, 32'h3F2AAAAB, 4'b0010);
        add_vec("overflow",  1'b0, 8'd254, 8'd1,   26'h2000000, 1'b0, 3'd0, 32'h7F800000, 4'b1010);
`ifdef DIV_SUBNORMAL_EN
        add_vec("tiny",      1'b0, 8'd1,   8'd129, 26'h2000000, 1'b0, 3'd0, 32'h00200000, 4'b0000);
        add_vec("e_zero",    1'b0, 8'd0,   8'd127, 26'h2000000, 1'b0, 3'd0, 32'h00400000, 4'b0000);
`else
        add_vec("tiny",      1'b0, 8'd1,   8'd129, 26'h2000000, 1'b0, 3'd0, 32'h00000000, 4'b0110);
        add_vec("e_zero",    1'b0, 8'd0,   8'd127, 26'h2000000, 1'b0, 3'd0, 32'h00000000, 4'b0110);
`endif
        add_vec("div_zero",  1'b1, 8'd0,   8'd0,   26'h0,       1'b0, 3'd4, 32'hFF800000, 4'b0001);
        add_vec("nan",       1'b1, 8'd10,  8'd20,  26'h2000000, 1'b0, 3'd3, 32'h7FC00000, 4'b0000);
        add_vec("zero_neg",  1'b1, 8'd10,  8'd20,  26'h2000000, 1'b0, 3'd1, 32'h80000000, 4'b0000);
        add_vec("inf_pos",   1'b0, 8'd10,  8'd20,  26'h2000000, 1'b0, 3'd2, 32'h7F800000, 4'b0000);
        add_vec("one",       1'b0, 8'd127, 8'd127, 26'h2000000, 1'b0, 3'd0, 32'h3F800000, 4'b0000);
        add_vec("tie_even",  1'b0, 8'd127, 8'd127, 26'h2000002, 1'b0, 3'd0, 32'h3F800000, 4'b0010);
        add_vec("tie_odd",   1'b0, 8'd127, 8'd127, 26'h2000006, 1'b0, 3'd0, 32'h3F800002, 4'b0010);
        add_vec("carry",     1'b1, 8'd127, 8'd127, 26'h3FFFFFE, 1'b0, 3'd0, 32'hC0000000, 4'b0010);
        add_vec("max_norm",  1'b0, 8'd254, 8'd127, 26'h3FFFFFC, 1'b0, 3'd0, 32'h7F7FFFFF, 4'b0000);
        add_vec("ovf_round", 1'b0, 8'd254, 8'd127, 26'h3FFFFFE, 1'b0, 3'd0, 32'h7F800000, 4'b1010);
        add_vec("min_norm",  1'b0, 8'd1,   8'd127, 26'h2000000, 1'b0, 3'd0, 32'h00800000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: three back-to-back quotients against a stalled consumer.
        va = vecs[0]; vb = vecs[1]; vc = vecs[9];
        exp_bp[0] = {va.exp_q, va.exp_flags};
        exp_bp[1] = {vb.exp_q, vb.exp_flags};
        exp_bp[2] = {vc.exp_q, vc.exp_flags};
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(va); bus.in_valid = 1'b1;
        #1; check("bp_accept_a", 36'(bus.in_ready), 36'(1));
        @(negedge clk);
        drive(vb);
        #1; check("bp_accept_b", 36'(bus.in_ready), 36'(1));
        @(negedge clk);
        drive(vc);
        #1;
        check("bp_full", 36'(bus.in_ready), 36'(0));
        check("bp_hold_valid", 36'(bus.out_valid), 36'(1));
        check("bp_hold_q0", {bus.out_q, bus.out_flags}, exp_bp[0]);
        @(negedge clk);
        #1;
        check("bp_still_full", 36'(bus.in_ready), 36'(0));
        check("bp_hold_q1", {bus.out_q, bus.out_flags}, exp_bp[0]);
        got = 0;
        c_acc = 1'b0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (c_acc) bus.in_valid = 1'b0;
            #1;
            if (bus.in_valid && bus.in_ready) c_acc = 1'b1;
            if (bus.out_valid) begin
                check($sformatf("bp_order%0d", got), {bus.out_q, bus.out_flags}, exp_bp[got]);
                got++;
            end
        end
        check("bp_count", 36'(got), 36'(3));
        @(negedge clk);
        bus.in_valid = 1'b0;

        // Reset while two results are stalled in the pipe.
        bus.out_ready = 1'b0;
        drive(va); bus.in_valid = 1'b1;
        @(negedge clk);
        drive(vb);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("rst_pre_valid", 36'(bus.out_valid), 36'(1));
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 36'(bus.out_valid), 36'(0));
        check("rst_out_q", 36'(bus.out_q), 36'(0));
        @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        emitted = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (bus.out_valid) emitted++;
        end
        check("rst_discard", 36'(emitted), 36'(0));

        // Random traffic with random consumer stalls, scored in order.
        have = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (have == 0) begin
                if ($urandom_range(0, 99) < 70) begin
                    gen_rand(v);
                    drive(v);
                    bus.in_valid = 1'b1;
                    have = 1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 99) < 65);
            #1;
            if (prev_stall) check("rand_stable", {bus.out_q, bus.out_flags}, prev_out);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_unexpected", 36'(1), 36'(0));
                end else begin
                    e = sb.pop_front();
                    check("rand_result", {bus.out_q, bus.out_flags}, e);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_q, bus.out_flags};
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_model(bus.in_sign, bus.in_rexp, bus.in_dexp,
                                       bus.in_qmant, bus.in_sticky, bus.in_special));
                have = 0;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            #1;
            if (bus.out_valid) begin
                e = sb.pop_front();
                check("drain_result", {bus.out_q, bus.out_flags}, e);
            end
            @(negedge clk);
        end
        check("drain_empty", 36'(sb.size()), 36'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
